chan_scan_seq: RTL and testbench

Upstream sequencer that drives the 3-bit select code of the 8:1 four-bit channel selector. It replaces free-running random select stimulus with a controlled channel sweep. The sweep uses a per-channel enable mask, a programmable dwell time, pause and stop controls, and single-sweep or continuous modes. The block outputs a select code, a valid flag, and step and sweep-complete strobes for downstream sampling logic.

---
 rtl/scan_pkg.sv | 22 ++
 rtl/chan_scan_seq_if.sv | 33 +++
 rtl/next_chan_find.sv | 40 ++++
 rtl/chan_scan_seq.sv | 109 ++++++++++
 tb/tb_chan_scan_seq.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/scan_pkg.sv
// Shared definitions for the channel scan sequencer.
//   NCH      number of selectable channels
//   SEL_W    select code width (log2 NCH)
//   DWELL_W  width of the dwell-time input
//   NO_CH    finder sentinel meaning "no enabled channel found"
//   state_e  sequencer FSM states
package scan_pkg;

  localparam int unsigned NCH     = 8;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned DWELL_W = 8;

  // One past the last valid index, so it can never alias a real channel.
  localparam int unsigned NO_CH   = NCH;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    PAUSE
  } state_e;

endpackage

// File: rtl/chan_scan_seq_if.sv
// Control/status bundle between the sweep controller and the scan sequencer.
//   start, stop, hold, single  sweep controls (levels)
//   mask                       per-channel enable
//   dwell                      per-channel dwell time (dwell+1 cycles)
//   sel, sel_valid             select code to the channel selector
//   ch_step, sweep_done        one-cycle strobes
//   busy                       sequencer is not idle
// master: drives controls, observes status. slave: the sequencer.
interface chan_scan_seq_if;

  logic                         start;
  logic                         stop;
  logic                         hold;
  logic                         single;
  logic [scan_pkg::NCH-1:0]     mask;
  logic [scan_pkg::DWELL_W-1:0] dwell;
  logic [scan_pkg::SEL_W-1:0]   sel;
  logic                         sel_valid;
  logic                         ch_step;
  logic                         sweep_done;
  logic                         busy;

  modport master (
    output start, stop, hold, single, mask, dwell,
    input  sel, sel_valid, ch_step, sweep_done, busy
  );

  modport slave (
    input  start, stop, hold, single, mask, dwell,
    output sel, sel_valid, ch_step, sweep_done, busy
  );

endinterface

// File: rtl/next_chan_find.sv
// Combinational next-channel finder.
//   mask      channel enable mask
//   cur       currently selected channel
//   next_idx  lowest enabled channel strictly above cur, else lowest overall
//   wrap      no enabled channel above cur (next_idx came from the wrap)
//   lowest    lowest enabled channel (0 when mask is empty)
//   any_en    at least one channel enabled
module next_chan_find
  import scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] cur,
  output logic [SEL_W-1:0] next_idx,
  output logic             wrap,
  output logic [SEL_W-1:0] lowest,
  output logic             any_en
);

  int unsigned lo;
  int unsigned above;

  always_comb begin
    lo    = NO_CH;
    above = NO_CH;
    // Scan downward so the last hit is the lowest matching index.
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        lo = int'(i);
        if (i > int'(cur)) begin
          above = int'(i);
        end
      end
    end
    any_en   = |mask;
    wrap     = (above == NO_CH);
    lowest   = SEL_W'(lo);
    next_idx = wrap ? SEL_W'(lo) : SEL_W'(above);
  end

endmodule

// File: rtl/chan_scan_seq.sv
// Channel scan sequencer: sweeps the 3-bit select code of the 8:1 channel
// selector over the enabled channels with a programmable dwell.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    control/status bundle (slave side), see chan_scan_seq_if
// All outputs are registered; busy decodes the state register only.
module chan_scan_seq
  import scan_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  chan_scan_seq_if.slave bus
);

  state_e               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic                 sel_valid_q;
  logic                 ch_step_q;
  logic                 sweep_done_q;
  logic [DWELL_W-1:0]   cnt_q;
  logic                 single_q;

  logic [SEL_W-1:0]     next_idx;
  logic                 wrap;
  logic [SEL_W-1:0]     lowest;
  logic                 any_en;

  next_chan_find u_find (
    .mask     (bus.mask),
    .cur      (sel_q),
    .next_idx (next_idx),
    .wrap     (wrap),
    .lowest   (lowest),
    .any_en   (any_en)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      sel_q        <= '0;
      sel_valid_q  <= 1'b0;
      ch_step_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      cnt_q        <= '0;
      single_q     <= 1'b0;
    end else begin
      ch_step_q    <= 1'b0;
      sweep_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.start && any_en) begin
            state_q     <= SCAN;
            sel_q       <= lowest;
            cnt_q       <= bus.dwell;
            sel_valid_q <= 1'b1;
            ch_step_q   <= 1'b1;
            single_q    <= bus.single;
          end
        end
        SCAN: begin
          if (bus.stop) begin
            state_q     <= IDLE;
            sel_valid_q <= 1'b0;
          end else if (bus.hold) begin
            // The cycle that samples hold still presented sel in SCAN, so it
            // counts toward the dwell; only PAUSE cycles are frozen.
            state_q <= PAUSE;
            if (cnt_q != '0) begin
              cnt_q <= cnt_q - DWELL_W'(1);
            end
          end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - DWELL_W'(1);
          end else if (!any_en) begin
            state_q     <= IDLE;
            sel_valid_q <= 1'b0;
          end else if (wrap && single_q) begin
            state_q      <= IDLE;
            sel_valid_q  <= 1'b0;
            sweep_done_q <= 1'b1;
          end else begin
            sel_q        <= next_idx;
            cnt_q        <= bus.dwell;
            ch_step_q    <= 1'b1;
            sweep_done_q <= wrap;
          end
        end
        PAUSE: begin
          if (bus.stop) begin
            state_q     <= IDLE;
            sel_valid_q <= 1'b0;
          end else if (!bus.hold) begin
            state_q <= SCAN;
          end
        end
        default: begin
          state_q     <= IDLE;
          sel_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sel        = sel_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.ch_step    = ch_step_q;
  assign bus.sweep_done = sweep_done_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_chan_scan_seq.sv
// Directed self-checking bench for chan_scan_seq.
module tb_chan_scan_seq;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  chan_scan_seq_if bus ();

  chan_scan_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int sel, input bit valid, input bit stp,
                         input bit done, input bit bsy);
    chk({tag, ".sel"}, 32'(bus.sel), 32'(sel));
    chk({tag, ".sel_valid"}, 32'(bus.sel_valid), 32'(valid));
    chk({tag, ".ch_step"}, 32'(bus.ch_step), 32'(stp));
    chk({tag, ".sweep_done"}, 32'(bus.sweep_done), 32'(done));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(bsy));
  endtask

  int seq2 [7] = '{2, 5, 7, 2, 5, 7, 2};

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.stop   = 1'b0;
    bus.hold   = 1'b0;
    bus.single = 1'b0;
    bus.mask   = 8'h00;
    bus.dwell  = 8'd0;
    repeat (2) @(posedge clk);
    #1;
    chk_out("reset", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("post_reset", 0, 0, 0, 0, 0);

    // Single sweep over all channels, one cycle each.
    bus.mask   = 8'hFF;
    bus.dwell  = 8'd0;
    bus.single = 1'b1;
    bus.start  = 1'b1;
    step();
    bus.start  = 1'b0;
    chk_out("t1_load", 0, 1, 1, 0, 1);
    for (int k = 1; k < 8; k++) begin
      step();
      chk_out("t1_step", k, 1, 1, 0, 1);
    end
    step();
    chk_out("t1_end", 7, 0, 0, 1, 0);
    step();
    chk_out("t1_idle", 7, 0, 0, 0, 0);

    // Continuous sweep over channels 2,5,7 with a 3-cycle dwell.
    bus.mask   = 8'b1010_0100;
    bus.dwell  = 8'd2;
    bus.single = 1'b0;
    bus.start  = 1'b1;
    for (int v = 0; v < 7; v++) begin
      for (int c = 0; c < 3; c++) begin
        step();
        bus.start = 1'b0;
        chk_out("t2_seq", seq2[v], 1, (c == 0), (c == 0 && v > 0 && seq2[v] == 2), 1);
      end
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_out("t2_stop", 2, 0, 0, 0, 0);

    // Hold on channel 0 for five cycles, then walk on and stop on channel 4.
    bus.mask  = 8'hFF;
    bus.dwell = 8'd3;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("t3_load", 0, 1, 1, 0, 1);
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t3_hold", 0, 1, 0, 0, 1);
    end
    bus.hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t3_resume", 0, 1, 0, 0, 1);
    end
    step();
    chk_out("t3_adv", 1, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t3_ch1", 1, 1, 0, 0, 1);
    end
    for (int ch = 2; ch < 4; ch++) begin
      for (int c = 0; c < 4; c++) begin
        step();
        chk_out("t3_walk", ch, 1, (c == 0), 0, 1);
      end
    end
    step();
    chk_out("t3_ch4", 4, 1, 1, 0, 1);
    step();
    chk_out("t3_ch4_mid", 4, 1, 0, 0, 1);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_out("t3_stop", 4, 0, 0, 0, 0);

    // Only channel 4 enabled: reselect with ch_step and sweep_done together.
    bus.mask  = 8'b0001_0000;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("t4_load", 4, 1, 1, 0, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_out("t4_dwell", 4, 1, 0, 0, 1);
      step();
      chk_out("t4_wrap", 4, 1, 1, 1, 1);
    end
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    chk_out("t4_stop", 4, 0, 0, 0, 0);

    // Start with an empty mask is ignored.
    bus.mask  = 8'h00;
    bus.start = 1'b1;
    step();
    chk_out("t5_empty", 4, 0, 0, 0, 0);
    step();
    chk_out("t5_empty2", 4, 0, 0, 0, 0);
    bus.start = 1'b0;

    // Mask cleared mid-dwell: current channel finishes, then idle, no sweep_done.
    bus.mask  = 8'hFF;
    bus.dwell = 8'd1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk_out("t6_load", 0, 1, 1, 0, 1);
    bus.mask = 8'h00;
    step();
    chk_out("t6_finish", 0, 1, 0, 0, 1);
    step();
    chk_out("t6_drop", 0, 0, 0, 0, 0);

    // Asynchronous reset mid-sweep.
    bus.mask  = 8'hFF;
    bus.dwell = 8'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    chk_out("t7_pre", 2, 1, 1, 0, 1);
    rst_n = 1'b0;
    #2;
    chk_out("t7_async", 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    step();
    chk_out("t7_after", 0, 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
